regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Drives the register file's single write port (regWrite/writeReg/writeData) from two producers:
  - Source A: the in-order pipeline writeback. Always accepted, highest priority.
  - Source B: the multi-cycle unit (mult/div, late loads). Uses a valid/ready handshake and is buffered in a DEPTH-entry FIFO.
- Drops writes to $zero.
- Squashes stale B results overwritten by a younger A write.
- Provides two combinational bypass query ports so decode can see writes that have not yet reached the register file.

Parameters:
- WIDTH, 32, data width of write data.
- DEPTH, 4, B-side FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  pipeline writeback request this cycle.
- a_reg  in  5  destination register for A.
- a_data  in  WIDTH  write data for A.
- b_valid  in  1  multi-cycle result valid.
- b_ready  out  1  FIFO can accept B.
- b_reg  in  5  destination register for B.
- b_data  in  WIDTH  write data for B.
- regWrite  out  1  register file write enable (registered).
- writeReg  out  5  register file write address (registered).
- writeData  out  WIDTH  register file write data (registered).
- pending_count  out  log2(DEPTH)+1  number of occupied FIFO slots, including squashed slots.
- q_reg1  in  5  bypass query address 1.
- q_hit1  out  1  a pending or in-flight write targets q_reg1.
- q_data1  out  WIDTH  newest pending data for q_reg1.
- q_reg2, q_hit2, q_data2  as port 1.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; all entry valid bits cleared.
  - regWrite=0, writeReg=0, writeData=0, pending_count=0.
  - b_ready=0 while rst is high, then 1 on the first cycle after release.
- b_ready = (pending_count < DEPTH). It does not account for a same-cycle pop.
- Accept:
  - A B transfer occurs when b_valid && b_ready at the clock edge.
  - Entry appended with valid=1, unless b_reg==0; then the transfer is accepted and discarded (no slot used).
- Output stage (one register, updated every edge):
  - If a_valid && a_reg!=0: the output captures A (regWrite=1). Latency is 1 cycle: A in cycle N gives the write in cycle N+1.
  - Else, if the FIFO head is valid: the output captures the head and pops it. Earliest case: B accepted at the edge ending cycle N is written in cycle N+2.
  - Else: regWrite=0, and writeReg/writeData hold their previous values.
  - An A request with a_reg==0 is ignored entirely and does not block B.
- Squashed head:
  - Popped in any cycle (even while A owns the output), one per cycle, with no write.
  - A valid head cannot pop in a cycle where A owns the output.
- Squash rule:
  - When A issues to register R (R!=0), every FIFO entry present before that edge with reg==R has its valid bit cleared.
  - A B entry accepted on the same edge is younger and is not squashed.
- Simultaneous accept and pop on one edge: pending_count is unchanged; pointers wrap modulo DEPTH.
- Bypass query (combinational, per port):
  - q_reg==0: hit=0, data=0.
  - Else the hit source is, in priority order:
    - the youngest valid FIFO entry with a matching reg;
    - otherwise the output stage, if regWrite && writeReg==q_reg;
    - otherwise hit=0, data=0.
  - Squashed entries never hit.
- Full FIFO: b_ready=0. A B request with b_valid=1 must hold its reg/data stable until accepted.
- Reset asserted mid-operation clears pending entries immediately; their writes are lost.

Test Plan:
- A only: a_valid=1, a_reg=5, a_data=0x1234 in cycle 0 → cycle 1 shows regWrite=1, writeReg=5, writeData=0x1234; cycle 2 shows regWrite=0.
- B with contention:
  - Stimulus: B(reg 7, 0xAAAA) accepted at edge 0; A(reg 3, 0x1) active in cycles 1-2.
  - Required: writes to r3 in cycles 2-3; r7=0xAAAA written in cycle 4; pending_count goes 1 → 0 after edge 3.
- Fill and backpressure:
  - Stimulus: hold a_valid=1 (reg 1); push 5 B requests (regs 8-12).
  - Required: b_ready=0 after 4 accepts; 5th held until A drops; B writes drain in order r8, r9, r10, r11, r12.
- Squash:
  - Stimulus: B(reg 9, 0xBEEF) queued; then A(reg 9, 0xCAFE).
  - Required: only r9=0xCAFE is written; the squashed entry pops with no write; q_hit1 for q_reg1=9 never returns 0xBEEF after the A edge.
- $zero and bypass:
  - A(reg 0) and B(reg 0) produce no regWrite and no FIFO growth.
  - With B entries r4=0x10 then r4=0x20 pending: q_reg2=4 gives q_hit2=1, q_data2=0x20.
- Async reset mid-drain: assert rst with 3 entries pending, between edges → regWrite=0 and pending_count=0 immediately; no stale writes after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// Source A (pipeline writeback) always wins the write port. Source B
// (multi-cycle results) is queued in a small FIFO and drains when A is idle.
// A younger A write to the same register squashes queued B results, and two
// bypass ports let decode see writes that have not reached the register file.
//
// Handshake on B: a transfer happens on a rising edge where b_valid and
// b_ready are both high. b_ready reflects FIFO occupancy only (not a
// same-cycle pop). While b_valid is high and b_ready is low, the producer
// holds b_reg/b_data stable.
module regfile_write_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   input  logic [4:0]               a_reg,
   input  logic [WIDTH-1:0]         a_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [4:0]               b_reg,
   input  logic [WIDTH-1:0]         b_data,
   output logic                     regWrite,
   output logic [4:0]               writeReg,
   output logic [WIDTH-1:0]         writeData,
   output logic [$clog2(DEPTH):0]   pending_count,
   input  logic [4:0]               q_reg1,
   output logic                     q_hit1,
   output logic [WIDTH-1:0]         q_data1,
   input  logic [4:0]               q_reg2,
   output logic                     q_hit2,
   output logic [WIDTH-1:0]         q_data2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // FIFO storage; ent_valid marks live (not squashed, occupied) entries
   logic             ent_valid_q [DEPTH];
   logic             ent_valid_d [DEPTH];
   logic [4:0]       ent_reg_q   [DEPTH];
   logic [4:0]       ent_reg_d   [DEPTH];
   logic [WIDTH-1:0] ent_data_q  [DEPTH];
   logic [WIDTH-1:0] ent_data_d  [DEPTH];

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Output stage registers
   logic             reg_write_q, reg_write_d;
   logic [4:0]       write_reg_q, write_reg_d;
   logic [WIDTH-1:0] write_data_q, write_data_d;

   logic             a_win;
   logic             head_present;
   logic             head_valid;
   logic             pop;
   logic             push;

   // A with a nonzero destination owns the output; $zero writes vanish.
   assign a_win        = a_valid && (a_reg != 5'd0);
   assign head_present = (count_q != '0);
   assign head_valid   = head_present && ent_valid_q[rd_ptr_q];
   // A squashed head always leaves; a live head leaves only when A is idle.
   assign pop          = head_present && (!head_valid || !a_win);
   // Writes to $zero are accepted but never occupy a slot.
   assign push         = b_valid && b_ready && (b_reg != 5'd0);

   assign b_ready       = !rst && (count_q < FULL_CNT);
   assign pending_count = count_q;
   assign regWrite      = reg_write_q;
   assign writeReg      = write_reg_q;
   assign writeData     = write_data_q;

   // Next-state for FIFO contents, pointers, occupancy and the output stage
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid_d[i] = ent_valid_q[i];
         ent_reg_d[i]   = ent_reg_q[i];
         ent_data_d[i]  = ent_data_q[i];
      end
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      // Output selection: A first, then a live FIFO head, else idle/hold.
      if (a_win) begin
         reg_write_d  = 1'b1;
         write_reg_d  = a_reg;
         write_data_d = a_data;
      end else if (head_valid) begin
         reg_write_d  = 1'b1;
         write_reg_d  = ent_reg_q[rd_ptr_q];
         write_data_d = ent_data_q[rd_ptr_q];
      end

      // Older queued results to the register A is writing are now stale.
      if (a_win) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_reg_q[i] == a_reg) begin
               ent_valid_d[i] = 1'b0;
            end
         end
      end

      if (pop) begin
         ent_valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d              = rd_ptr_q + 1'b1;
      end

      // Applied after the squash so a same-edge B entry survives as younger.
      if (push) begin
         ent_valid_d[wr_ptr_q] = 1'b1;
         ent_reg_d[wr_ptr_q]   = b_reg;
         ent_data_d[wr_ptr_q]  = b_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end

      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_valid_q[i] <= 1'b0;
            ent_reg_q[i]   <= '0;
            ent_data_q[i]  <= '0;
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_valid_q[i] <= ent_valid_d[i];
            ent_reg_q[i]   <= ent_reg_d[i];
            ent_data_q[i]  <= ent_data_d[i];
         end
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   logic [4:0]       q_reg_a  [2];
   logic             q_hit_a  [2];
   logic [WIDTH-1:0] q_data_a [2];

   assign q_reg_a[0] = q_reg1;
   assign q_reg_a[1] = q_reg2;
   assign q_hit1     = q_hit_a[0];
   assign q_data1    = q_data_a[0];
   assign q_hit2     = q_hit_a[1];
   assign q_data2    = q_data_a[1];

   // Bypass lookup: youngest live FIFO match, else the output stage
   always_comb begin
      logic [PW-1:0] idx;
      idx = '0;
      for (int p = 0; p < 2; p++) begin
         q_hit_a[p]  = 1'b0;
         q_data_a[p] = '0;
         if (q_reg_a[p] != 5'd0) begin
            if (reg_write_q && (write_reg_q == q_reg_a[p])) begin
               q_hit_a[p]  = 1'b1;
               q_data_a[p] = write_data_q;
            end
            // Walk oldest to youngest so the last match found is the newest.
            for (int k = 0; k < DEPTH; k++) begin
               idx = rd_ptr_q + PW'(k);
               if ((CW'(k) < count_q) && ent_valid_q[idx] &&
                   (ent_reg_q[idx] == q_reg_a[p])) begin
                  q_hit_a[p]  = 1'b1;
                  q_data_a[p] = ent_data_q[idx];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [4:0]       a_reg;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [4:0]       b_reg;
  logic [WIDTH-1:0] b_data;
  logic             regWrite;
  logic [4:0]       writeReg;
  logic [WIDTH-1:0] writeData;
  logic [2:0]       pending_count;
  logic [4:0]       q_reg1;
  logic             q_hit1;
  logic [WIDTH-1:0] q_data1;
  logic [4:0]       q_reg2;
  logic             q_hit2;
  logic [WIDTH-1:0] q_data2;

  int n_cmp;
  int n_err;
  logic [4:0] exp_q[$];
  logic [4:0] exp_r;
  logic       acc;
  int         budget;

  regfile_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .pending_count(pending_count),
    .q_reg1(q_reg1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_reg2(q_reg2), .q_hit2(q_hit2), .q_data2(q_data2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r, input logic [WIDTH-1:0] d);
    a_valid = v;
    a_reg   = r;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] r, input logic [WIDTH-1:0] d);
    b_valid = v;
    b_reg   = r;
    b_data  = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive_a(1'b0, 5'd0, '0);
    drive_b(1'b0, 5'd0, '0);
    q_reg1 = 5'd0;
    q_reg2 = 5'd0;

    // reset state
    #3;
    check_eq("rst_regwrite", regWrite, 0);
    check_eq("rst_writereg", writeReg, 0);
    check_eq("rst_writedata", writeData, 0);
    check_eq("rst_pending", pending_count, 0);
    check_eq("rst_bready", b_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rel_bready", b_ready, 1);

    // A only
    drive_a(1'b1, 5'd5, 32'h1234);
    tick();
    check_eq("a_regwrite", regWrite, 1);
    check_eq("a_writereg", writeReg, 5);
    check_eq("a_writedata", writeData, 32'h1234);
    drive_a(1'b0, 5'd0, '0);
    tick();
    check_eq("a_idle_regwrite", regWrite, 0);
    check_eq("a_idle_hold_reg", writeReg, 5);
    check_eq("a_idle_hold_data", writeData, 32'h1234);

    // B with contention
    drive_b(1'b1, 5'd7, 32'hAAAA);
    tick();
    drive_b(1'b0, 5'd0, '0);
    check_eq("bc_pend_e0", pending_count, 1);
    drive_a(1'b1, 5'd3, 32'h1);
    tick();
    check_eq("bc_c2_reg", writeReg, 3);
    check_eq("bc_c2_pend", pending_count, 1);
    tick();
    check_eq("bc_c3_wr", regWrite, 1);
    check_eq("bc_c3_reg", writeReg, 3);
    drive_a(1'b0, 5'd0, '0);
    tick();
    check_eq("bc_c4_wr", regWrite, 1);
    check_eq("bc_c4_reg", writeReg, 7);
    check_eq("bc_c4_data", writeData, 32'hAAAA);
    check_eq("bc_c4_pend", pending_count, 0);
    tick();
    check_eq("bc_c5_idle", regWrite, 0);

    // fill and backpressure
    drive_a(1'b1, 5'd1, 32'h11);
    for (int r = 8; r <= 11; r++) begin
      drive_b(1'b1, 5'(r), 32'h100 + r);
      #1;
      check_eq("fill_ready", b_ready, 1);
      tick();
    end
    drive_b(1'b1, 5'd12, 32'h10C);
    #1;
    check_eq("full_bready", b_ready, 0);
    check_eq("full_pend", pending_count, 4);
    tick();
    check_eq("full_hold_pend", pending_count, 4);
    check_eq("full_a_reg", writeReg, 1);
    drive_a(1'b0, 5'd0, '0);
    #1;
    check_eq("full_bready2", b_ready, 0);
    exp_q.delete();
    for (int r = 8; r <= 12; r++) exp_q.push_back(5'(r));
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      acc = b_valid && b_ready;
      tick();
      budget--;
      if (acc) begin
        drive_b(1'b0, 5'd0, '0);
        check_eq("simul_push_pop", pending_count, 3);
      end
      if (regWrite) begin
        exp_r = exp_q.pop_front();
        check_eq("drain_reg", writeReg, exp_r);
        check_eq("drain_data", writeData, 32'h100 + exp_r);
      end
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_pend", pending_count, 0);
    drive_b(1'b0, 5'd0, '0);
    tick();

    // squash
    drive_b(1'b1, 5'd9, 32'hBEEF);
    tick();
    drive_b(1'b0, 5'd0, '0);
    q_reg1 = 5'd9;
    #1;
    check_eq("sq_pre_hit", q_hit1, 1);
    check_eq("sq_pre_data", q_data1, 32'hBEEF);
    drive_a(1'b1, 5'd9, 32'hCAFE);
    tick();
    check_eq("sq_a_reg", writeReg, 9);
    check_eq("sq_a_data", writeData, 32'hCAFE);
    check_eq("sq_pend_kept", pending_count, 1);
    check_eq("sq_q_data", q_data1, 32'hCAFE);
    drive_a(1'b1, 5'd3, 32'h3);
    tick();
    check_eq("sq_pop_under_a", pending_count, 0);
    check_eq("sq_a2_reg", writeReg, 3);
    check_eq("sq_q_hit_gone", q_hit1, 0);
    drive_a(1'b0, 5'd0, '0);
    tick();
    check_eq("sq_no_write", regWrite, 0);

    // same-edge A and B to one register: B is younger and survives
    drive_a(1'b1, 5'd6, 32'h66);
    drive_b(1'b1, 5'd6, 32'h77);
    tick();
    drive_a(1'b0, 5'd0, '0);
    drive_b(1'b0, 5'd0, '0);
    check_eq("same_a_data", writeData, 32'h66);
    check_eq("same_pend", pending_count, 1);
    q_reg1 = 5'd6;
    #1;
    check_eq("same_q_data", q_data1, 32'h77);
    tick();
    check_eq("same_b_wr", regWrite, 1);
    check_eq("same_b_data", writeData, 32'h77);

    // $zero writes
    drive_a(1'b1, 5'd0, 32'hDEAD);
    drive_b(1'b1, 5'd0, 32'hDEAD);
    tick();
    drive_b(1'b0, 5'd0, '0);
    drive_a(1'b0, 5'd0, '0);
    check_eq("zero_regwrite", regWrite, 0);
    check_eq("zero_pend", pending_count, 0);

    // A to $zero does not block B
    drive_b(1'b1, 5'd5, 32'h55);
    tick();
    drive_b(1'b0, 5'd0, '0);
    drive_a(1'b1, 5'd0, 32'h99);
    tick();
    drive_a(1'b0, 5'd0, '0);
    check_eq("zero_a_b_wr", regWrite, 1);
    check_eq("zero_a_b_reg", writeReg, 5);
    check_eq("zero_a_b_data", writeData, 32'h55);

    // bypass with several pending entries
    drive_a(1'b1, 5'd2, 32'h22);
    drive_b(1'b1, 5'd4, 32'h10);
    tick();
    drive_b(1'b1, 5'd4, 32'h20);
    tick();
    drive_b(1'b1, 5'd13, 32'h33);
    tick();
    drive_a(1'b0, 5'd0, '0);
    drive_b(1'b0, 5'd0, '0);
    check_eq("byp_pend", pending_count, 3);
    q_reg2 = 5'd4;
    q_reg1 = 5'd13;
    #1;
    check_eq("byp_hit2", q_hit2, 1);
    check_eq("byp_data2", q_data2, 32'h20);
    check_eq("byp_data1", q_data1, 32'h33);
    q_reg1 = 5'd2;
    q_reg2 = 5'd0;
    #1;
    check_eq("byp_out_hit", q_hit1, 1);
    check_eq("byp_out_data", q_data1, 32'h22);
    check_eq("byp_zero_hit", q_hit2, 0);
    check_eq("byp_zero_data", q_data2, 0);

    // async reset between edges with entries pending
    rst = 1'b1;
    #1;
    check_eq("ar_regwrite", regWrite, 0);
    check_eq("ar_pend", pending_count, 0);
    check_eq("ar_bready", b_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("ar_no_stale", regWrite, 0);
      check_eq("ar_pend_after", pending_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
